// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game auto player: state encoding,
// one-hot move constants, the default move sequence and small helpers.
package jogo_pkg;

   // State encoding, also exported unchanged on db_estado
   typedef enum logic [3:0] {
      E_INICIAL          = 4'd0,
      E_PULSO_INICIAR    = 4'd1,
      E_ESPERA_INICIAL   = 4'd2,
      E_APRESENTA        = 4'd3,
      E_INTERVALO        = 4'd4,
      E_ESPERA_RESULTADO = 4'd5,
      E_FIM              = 4'd6
   } estado_t;

   // One-hot moves, one per game switch
   localparam logic [3:0] J_0 = 4'b0001;
   localparam logic [3:0] J_1 = 4'b0010;
   localparam logic [3:0] J_2 = 4'b0100;
   localparam logic [3:0] J_3 = 4'b1000;

   localparam int N_JOGADAS_MAX = 16;

   // Default game sequence, element 0 is the first move played.
   // Written MSB-first, so the list below reads from move 15 down to move 0.
   localparam logic [15:0][3:0] SEQ_PADRAO = {
      J_2, J_0, J_3, J_3, J_2, J_2, J_1, J_1,
      J_0, J_0, J_1, J_2, J_3, J_2, J_1, J_0
   };

   // Deliberate wrong move: the next switch over, wrapping 1000 back to 0001
   function automatic logic [3:0] rotl1(input logic [3:0] m);
      return {m[2:0], m[3]};
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Player-side bus between the auto player and the memory game:
// iniciar/chaves go towards the game, the verdict flags come back.
interface jogador_automatico_if;

   logic       iniciar_out;
   logic [3:0] chaves_out;
   logic       pronto;
   logic       acertou;
   logic       errou;

   // The auto player drives the game inputs
   modport master (
      output iniciar_out,
      output chaves_out,
      input  pronto,
      input  acertou,
      input  errou
   );

   // The game consumes the moves and reports its verdict
   modport slave (
      input  iniciar_out,
      input  chaves_out,
      output pronto,
      output acertou,
      output errou
   );

endinterface

// File: rtl/rom_jogadas_16x4.sv
// Combinational 16x4 move ROM holding the default game sequence.
module rom_jogadas_16x4
   import jogo_pkg::*;
(
   input  logic [3:0] i_endereco,
   output logic [3:0] o_jogada
);

   assign o_jogada = SEQ_PADRAO[i_endereco];

endmodule

// File: rtl/jogador_automatico.sv
// Self-playing stimulus master for the memory game: pulses iniciar, replays
// the stored moves with fixed hold/gap times, optionally corrupts one move,
// and latches the game's verdict (or a timeout).
module jogador_automatico
   import jogo_pkg::*;
#(
   parameter int INIT_CYC    = 5,
   parameter int HOLD_CYC    = 10,
   parameter int GAP_CYC     = 10,
   parameter int NJOGADAS    = 16,
   parameter int TIMEOUT_CYC = 64
)
(
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        partida,
   input  logic                        erro_en,
   input  logic [3:0]                  erro_pos,
   jogador_automatico_if.master        jogo,
   output logic                        ocupado,
   output logic                        fim,
   output logic                        sucesso,
   output logic                        falha,
   output logic                        timeout,
   output logic [3:0]                  db_estado,
   output logic [3:0]                  db_indice
);

   // Cycle counter sized for the longest wait of any state
   localparam int MAX_CYC = max_int(max_int(INIT_CYC, HOLD_CYC),
                                    max_int(GAP_CYC, TIMEOUT_CYC));
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   // Terminal counts: a state of N cycles leaves when the counter reads N-1
   localparam logic [CNT_W-1:0] INIT_FIM    = CNT_W'(INIT_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_FIM    = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_FIM     = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_FIM = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [3:0]       ULTIMO      = 4'(NJOGADAS - 1);
   localparam logic [4:0]       NJOG_5      = 5'(NJOGADAS);

   estado_t          r_estado;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_indice;
   logic [3:0]       r_chaves;
   logic             r_iniciar;
   logic             r_ocupado;
   logic             r_fim;
   logic             r_sucesso;
   logic             r_falha;
   logic             r_timeout;

   logic [3:0]       w_rom_addr;
   logic [3:0]       w_rom_jogada;
   logic             w_injeta;
   logic [3:0]       w_jogada;
   logic             w_em_jogo;
   logic             w_veredito;

   // The ROM is looked up for the move about to be presented: from INTERVALO
   // that is the next index, everywhere else the current one.
   assign w_rom_addr = (r_estado == E_INTERVALO) ? (r_indice + 4'd1) : r_indice;

   rom_jogadas_16x4 u_rom (
      .i_endereco (w_rom_addr),
      .o_jogada   (w_rom_jogada)
   );

   // An erro_pos beyond the played sequence never matches a real move
   assign w_injeta = erro_en && (w_rom_addr == erro_pos) && ({1'b0, erro_pos} < NJOG_5);
   assign w_jogada = w_injeta ? rotl1(w_rom_jogada) : w_rom_jogada;

   // Verdicts only count once moves are being presented
   assign w_em_jogo  = (r_estado == E_APRESENTA) || (r_estado == E_INTERVALO) ||
                       (r_estado == E_ESPERA_RESULTADO);
   assign w_veredito = jogo.pronto || jogo.acertou || jogo.errou;

   // Main sequencer: state, counter, index and every registered output
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado  <= E_INICIAL;
         r_cnt     <= '0;
         r_indice  <= '0;
         r_chaves  <= '0;
         r_iniciar <= 1'b0;
         r_ocupado <= 1'b0;
         r_fim     <= 1'b0;
         r_sucesso <= 1'b0;
         r_falha   <= 1'b0;
         r_timeout <= 1'b0;
      end else if (w_em_jogo && w_veredito) begin
         // Early verdict: stop at once, truncating any move being held
         r_estado  <= E_FIM;
         r_cnt     <= '0;
         r_chaves  <= '0;
         r_ocupado <= 1'b0;
         r_fim     <= 1'b1;
         if (jogo.acertou) r_sucesso <= 1'b1;
         if (jogo.errou)   r_falha   <= 1'b1;
      end else begin
         case (r_estado)
            E_INICIAL, E_FIM: begin
               if (partida) begin
                  r_estado  <= E_PULSO_INICIAR;
                  r_cnt     <= '0;
                  r_indice  <= '0;
                  r_iniciar <= 1'b1;
                  r_ocupado <= 1'b1;
                  r_fim     <= 1'b0;
                  r_sucesso <= 1'b0;
                  r_falha   <= 1'b0;
                  r_timeout <= 1'b0;
               end
            end

            E_PULSO_INICIAR: begin
               if (r_cnt == INIT_FIM) begin
                  r_estado  <= E_ESPERA_INICIAL;
                  r_cnt     <= '0;
                  r_iniciar <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            E_ESPERA_INICIAL: begin
               if (r_cnt == GAP_FIM) begin
                  r_estado <= E_APRESENTA;
                  r_cnt    <= '0;
                  r_chaves <= w_jogada;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            E_APRESENTA: begin
               if (r_cnt == HOLD_FIM) begin
                  r_estado <= E_INTERVALO;
                  r_cnt    <= '0;
                  r_chaves <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            E_INTERVALO: begin
               if (r_cnt == GAP_FIM) begin
                  r_cnt <= '0;
                  if (r_indice == ULTIMO) begin
                     r_estado <= E_ESPERA_RESULTADO;
                  end else begin
                     r_estado <= E_APRESENTA;
                     r_indice <= r_indice + 4'd1;
                     r_chaves <= w_jogada;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            E_ESPERA_RESULTADO: begin
               if (r_cnt == TIMEOUT_FIM) begin
                  r_estado  <= E_FIM;
                  r_cnt     <= '0;
                  r_ocupado <= 1'b0;
                  r_fim     <= 1'b1;
                  r_timeout <= 1'b1;
                  r_falha   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_estado  <= E_INICIAL;
               r_cnt     <= '0;
               r_chaves  <= '0;
               r_iniciar <= 1'b0;
               r_ocupado <= 1'b0;
               r_fim     <= 1'b0;
            end
         endcase
      end
   end

   assign jogo.iniciar_out = r_iniciar;
   assign jogo.chaves_out  = r_chaves;
   assign ocupado          = r_ocupado;
   assign fim              = r_fim;
   assign sucesso          = r_sucesso;
   assign falha            = r_falha;
   assign timeout          = r_timeout;
   assign db_estado        = r_estado;
   assign db_indice        = r_indice;

endmodule
